// File: rtl/lenet_pkg.sv
// Shared types and defaults for the LeNet batch scheduler.
// Holds the FSM encoding and ping-pong buffer select constants.
package lenet_pkg;

    localparam int IMG_CNT_WIDTH_DEF  = 8;
    localparam int TO_WIDTH_DEF       = 20;
    localparam int TIMEOUT_CYCLES_DEF = 600000;

    // 1: CONV writes d, FC reads c; 0: CONV writes c, FC reads d
    localparam logic MEM_SEL_FC_READS_C = 1'b1;
    localparam logic MEM_SEL_FC_READS_D = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LAUNCH,
        WAIT,
        FINISH
    } state_t;

    function automatic logic epoch_mem_sel(input logic epoch_lsb);
        return epoch_lsb ? MEM_SEL_FC_READS_C : MEM_SEL_FC_READS_D;
    endfunction

endpackage

// File: rtl/epoch_watchdog.sv
// Per-epoch watchdog: counts enabled cycles since the last clear.
// expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module epoch_watchdog
    import lenet_pkg::*;
#(
    parameter int TO_WIDTH       = TO_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic srstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] ONE  = TO_WIDTH'(1);

    logic [TO_WIDTH-1:0] cnt;

    // Count enabled cycles, holding at the limit so it never wraps.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/lenet_pipe_scheduler.sv
// Batch scheduler: overlaps CONV of image e with FC of image e-1,
// flipping the c/d ping-pong select every epoch.
module lenet_pipe_scheduler
    import lenet_pkg::*;
#(
    parameter int IMG_CNT_WIDTH  = IMG_CNT_WIDTH_DEF,
    parameter int TO_WIDTH       = TO_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     start,
    input  logic [IMG_CNT_WIDTH-1:0] num_images,
    output logic                     busy,
    output logic                     done,
    output logic                     conv_start,
    input  logic                     conv_done,
    output logic                     fc_go,
    input  logic                     fc1_done,
    input  logic                     fc2_done,
    output logic                     mem_sel,
    output logic [IMG_CNT_WIDTH-1:0] img_conv_idx,
    output logic [IMG_CNT_WIDTH-1:0] img_fc_idx,
    output logic                     err_timeout,
    output logic                     err_protocol
);

    // Epoch count is one bit wider so N+1 epochs never wrap.
    localparam int            EW    = IMG_CNT_WIDTH + 1;
    localparam logic [EW-1:0] E_ONE = EW'(1);

    state_t                   state;
    logic [IMG_CNT_WIDTH-1:0] n_img;
    logic [EW-1:0]            epoch;
    logic [EW-1:0]            epoch_inc;
    logic [EW-1:0]            n_ext;
    logic                     conv_pend;
    logic                     fc_pend;
    logic                     fc1_seen;
    logic                     conv_pend_n;
    logic                     fc_pend_n;
    logic                     has_conv;
    logic                     has_fc;
    logic                     proto_hit;
    logic                     wd_expired;

    assign n_ext       = {1'b0, n_img};
    assign epoch_inc   = epoch + E_ONE;
    assign has_conv    = epoch < n_ext;
    assign has_fc      = epoch != '0;
    assign conv_pend_n = conv_pend && !conv_done;
    assign fc_pend_n   = fc_pend && !fc2_done;

    epoch_watchdog #(
        .TO_WIDTH       (TO_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .srstn   (srstn),
        .clear   (state == LAUNCH),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    // Flag any done input that arrives outside an open engine job.
    always_comb begin
        proto_hit = 1'b0;
        unique case (state)
            IDLE, SETUP, LAUNCH: begin
                proto_hit = conv_done || fc1_done || fc2_done;
            end
            WAIT: begin
                proto_hit = (conv_done && !conv_pend)
                         || ((fc1_done || fc2_done) && !fc_pend)
                         || (fc2_done && !fc1_seen && !fc1_done);
            end
            default: proto_hit = 1'b0;
        endcase
    end

    // Epoch sequencing, launch pulses, pend tracking and sticky errors.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state        <= IDLE;
            n_img        <= '0;
            epoch        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            conv_start   <= 1'b0;
            fc_go        <= 1'b0;
            mem_sel      <= MEM_SEL_FC_READS_D;
            img_conv_idx <= '0;
            img_fc_idx   <= '0;
            conv_pend    <= 1'b0;
            fc_pend      <= 1'b0;
            fc1_seen     <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            done       <= 1'b0;
            conv_start <= 1'b0;
            fc_go      <= 1'b0;
            if (proto_hit) begin
                err_protocol <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        n_img        <= num_images;
                        epoch        <= '0;
                        err_timeout  <= 1'b0;
                        err_protocol <= proto_hit;
                        mem_sel      <= epoch_mem_sel(1'b0);
                        img_conv_idx <= '0;
                        img_fc_idx   <= '0;
                        if (num_images == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    conv_start <= has_conv;
                    fc_go      <= has_fc;
                    conv_pend  <= has_conv;
                    fc_pend    <= has_fc;
                    fc1_seen   <= 1'b0;
                    state      <= LAUNCH;
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (wd_expired) begin
                        err_timeout <= 1'b1;
                        conv_pend   <= 1'b0;
                        fc_pend     <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        conv_pend <= conv_pend_n;
                        fc_pend   <= fc_pend_n;
                        if (fc1_done) begin
                            fc1_seen <= 1'b1;
                        end
                        if (!conv_pend_n && !fc_pend_n) begin
                            if (epoch == n_ext) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                epoch        <= epoch_inc;
                                mem_sel      <= epoch_mem_sel(epoch_inc[0]);
                                img_conv_idx <= epoch_inc[IMG_CNT_WIDTH-1:0];
                                img_fc_idx   <= epoch[IMG_CNT_WIDTH-1:0];
                                state        <= SETUP;
                            end
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_pipe_scheduler.sv
// Bench for lenet_pipe_scheduler: table-driven batches, random
// batches against an epoch-level timing model, timeout and reset cases.
module tb_lenet_pipe_scheduler;

    logic       clk = 1'b0;
    logic       srstn;
    logic       start;
    logic [7:0] num_images;
    logic       busy;
    logic       done;
    logic       conv_start;
    logic       conv_done;
    logic       fc_go;
    logic       fc1_done;
    logic       fc2_done;
    logic       mem_sel;
    logic [7:0] img_conv_idx;
    logic [7:0] img_fc_idx;
    logic       err_timeout;
    logic       err_protocol;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lenet_pipe_scheduler #(
        .IMG_CNT_WIDTH  (8),
        .TO_WIDTH       (20),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .num_images   (num_images),
        .busy         (busy),
        .done         (done),
        .conv_start   (conv_start),
        .conv_done    (conv_done),
        .fc_go        (fc_go),
        .fc1_done     (fc1_done),
        .fc2_done     (fc2_done),
        .mem_sel      (mem_sel),
        .img_conv_idx (img_conv_idx),
        .img_fc_idx   (img_fc_idx),
        .err_timeout  (err_timeout),
        .err_protocol (err_protocol)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs one batch. Engines answer each launch after lc/lf cycles
    // (0 = random). The model: epoch e launches CONV if e<n and FC if
    // e>=1; the next launch comes 2 cycles after the epoch's last done;
    // done comes 1 cycle after the last epoch's last done.
    task automatic run_batch(input int n, input int lc, input int lf,
                             input int skip_ep, input int abort_ep,
                             input bit perr, input bit noisy,
                             output int done_cyc, output int n_cs,
                             output int n_fg);
        int cyc;
        int ee;
        int launch_due;
        int done_due;
        int abort_at;
        int conv_at;
        int fc1_at;
        int fc2_at;
        int last;
        int lat;
        bit fin;
        done_cyc = -1;
        n_cs = 0;
        n_fg = 0;
        fin = 0;
        ee = 0;
        conv_at = -1;
        fc1_at = -1;
        fc2_at = -1;
        abort_at = -1;
        launch_due = (n == 0) ? -1 : 2;
        done_due = (n == 0) ? 1 : -1;
        start = 1'b1;
        num_images = 8'(n);
        @(posedge clk); #1;
        cyc = 1;
        start = 1'b0;
        chk("err_cleared", {err_timeout, err_protocol}, 0);
        while (!fin && cyc < 5000) begin
            if (cyc == abort_at) begin
                srstn = 1'b0;
                return;
            end
            chk("busy", busy, 1);
            n_cs += int'(conv_start);
            n_fg += int'(fc_go);
            if (cyc == launch_due) begin
                chk("conv_start", conv_start, ee < n);
                chk("fc_go", fc_go, ee >= 1);
                chk("mem_sel", mem_sel, ee % 2);
                chk("conv_idx", img_conv_idx, ee % 256);
                chk("fc_idx", img_fc_idx, (ee == 0) ? 0 : (ee - 1) % 256);
                conv_at = -1;
                fc1_at = -1;
                fc2_at = -1;
                if (ee < n) begin
                    lat = (lc > 0) ? lc : int'($urandom_range(8, 1));
                    conv_at = cyc + lat;
                end
                if (ee >= 1) begin
                    lat = (lf > 0) ? lf : int'($urandom_range(9, 2));
                    fc2_at = cyc + lat;
                    if (ee != skip_ep) begin
                        fc1_at = (lf > 0) ? fc2_at - 1
                               : int'($urandom_range(fc2_at - 1, cyc + 1));
                    end
                end
                last = (conv_at > fc2_at) ? conv_at : fc2_at;
                if (ee == abort_ep) abort_at = cyc + 3;
                if (ee == n) done_due = last + 1;
                else launch_due = last + 2;
                ee++;
            end else begin
                chk("stray_launch", {conv_start, fc_go}, 0);
            end
            if (cyc == done_due) begin
                chk("done", done, 1);
                chk("err_timeout", err_timeout, 0);
                chk("err_protocol", err_protocol, perr);
                chk("final_mem_sel", mem_sel, n % 2);
                done_cyc = cyc;
                fin = 1;
            end else begin
                chk("done_quiet", done, 0);
            end
            conv_done = (cyc == conv_at);
            fc1_done = (cyc == fc1_at);
            fc2_done = (cyc == fc2_at);
            start = (noisy && !fin) ? 1'($urandom_range(1, 0)) : 1'b0;
            if (noisy) num_images = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (fin) begin
            chk("busy_drop", busy, 0);
            chk("done_pulse", done, 0);
        end else begin
            chk("batch_bound", cyc, 0);
        end
    endtask

    typedef struct {
        int n;
        int lc;
        int lf;
        int skip;
        bit spur;
        bit perr;
        int exp_done;
        int exp_cs;
        int exp_fg;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int dc;
        int cs;
        int fg;
        tbl[0] = '{n:1,   lc:50, lf:3, skip:-1, spur:0, perr:0,
                   exp_done:58,   exp_cs:1,   exp_fg:1};
        tbl[1] = '{n:3,   lc:5,  lf:5, skip:-1, spur:0, perr:0,
                   exp_done:29,   exp_cs:3,   exp_fg:3};
        tbl[2] = '{n:2,   lc:2,  lf:6, skip:-1, spur:0, perr:0,
                   exp_done:21,   exp_cs:2,   exp_fg:2};
        tbl[3] = '{n:0,   lc:1,  lf:2, skip:-1, spur:0, perr:0,
                   exp_done:1,    exp_cs:0,   exp_fg:0};
        tbl[4] = '{n:2,   lc:3,  lf:4, skip:1,  spur:1, perr:1,
                   exp_done:18,   exp_cs:2,   exp_fg:2};
        tbl[5] = '{n:255, lc:1,  lf:2, skip:-1, spur:0, perr:0,
                   exp_done:1024, exp_cs:255, exp_fg:255};

        srstn = 1'b0;
        start = 1'b0;
        num_images = '0;
        conv_done = 1'b0;
        fc1_done = 1'b0;
        fc2_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, conv_start, fc_go, mem_sel,
            err_timeout, err_protocol, img_conv_idx, img_fc_idx}, 0);
        srstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].spur) begin
                conv_done = 1'b1;
                @(posedge clk); #1;
                conv_done = 1'b0;
                chk("spurious_idle", err_protocol, 1);
            end
            run_batch(tbl[i].n, tbl[i].lc, tbl[i].lf, tbl[i].skip, -1,
                      tbl[i].perr, 1'b0, dc, cs, fg);
            chk("tbl_done_cyc", dc, tbl[i].exp_done);
            chk("tbl_conv_cnt", cs, tbl[i].exp_cs);
            chk("tbl_fc_cnt", fg, tbl[i].exp_fg);
        end

        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'($urandom_range(6, 1));
            run_batch(n, 0, 0, -1, -1, 1'b0, 1'b1, dc, cs, fg);
            chk("rnd_conv_cnt", cs, n);
            chk("rnd_fc_cnt", fg, n);
        end

        // Withheld conv_done: 100th WAIT cycle expires, done next cycle.
        start = 1'b1;
        num_images = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = -1;
        for (int c = 1; c < 300 && dc < 0; c++) begin
            if (c == 2) chk("to_launch", conv_start, 1);
            if (done) begin
                dc = c;
                chk("to_err", err_timeout, 1);
                chk("to_perr", err_protocol, 0);
            end
            @(posedge clk); #1;
        end
        chk("to_done_cyc", dc, 103);
        chk("to_busy_drop", busy, 0);
        run_batch(0, 1, 2, -1, -1, 1'b0, 1'b0, dc, cs, fg);
        chk("to_cleared_done", dc, 1);

        // Reset in mid-WAIT of epoch 2, then a clean full batch.
        run_batch(3, 10, 10, -1, 2, 1'b0, 1'b0, dc, cs, fg);
        #1;
        chk("rst_mid", {busy, done, conv_start, fc_go, mem_sel,
            err_timeout, err_protocol, img_conv_idx, img_fc_idx}, 0);
        @(negedge clk);
        srstn = 1'b1;
        @(posedge clk); #1;
        run_batch(3, 0, 0, -1, -1, 1'b0, 1'b1, dc, cs, fg);
        chk("post_rst_conv_cnt", cs, 3);
        chk("post_rst_fc_cnt", fg, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
